cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Coprocessor-0 exception and interrupt controller for the single-cycle CPU. It receives the ALU overflow flag (`V`), decoder exception strobes and an external interrupt request. It holds the Status, Cause and EPC registers, services `mfc0`, `mtc0` and `eret`, and drives the PC-override mux that redirects fetch to the handler vector or back to EPC.

## Interface
Parameters:
- EXC_BASE, 32'h0000_0008, handler vector address
- STATUS_RST, 32'h0000_0000, Status value after reset

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Pc  in  32  address of current instruction
- Npc  in  32  address of next sequential instruction (Pc+4)
- V  in  1  ALU overflow flag
- OvChk  in  1  current instruction is overflow-trapping (add/addi/sub)
- Sys  in  1  current instruction is syscall
- Unimpl  in  1  current instruction is unimplemented
- Mfc0, Mtc0, Eret  in  1 each  decoder strobes
- C0Adr  in  5  CP0 register number (rd field)
- Wdata  in  32  mtc0 write data (rt value)
- IntR  in  1  external interrupt request, level
- IntA  out  1  interrupt acknowledge, one-cycle pulse
- Rdata  out  32  mfc0 read data, combinational
- ExcTaken  out  1  combinational; squash writeback of current instruction
- PcSel  out  2  00 = Npc/normal, 01 = EXC_BASE, 10 = Epc
- NewPc  out  32  override PC: EXC_BASE when PcSel=01, Epc when 10, else 0
- Status, Cause, Epc  out  32 each  register contents

## Operation
- Registers: Status (12), Cause (13), EPC (14).
- Status[3:0] are enables {Ov, Unimpl, Sys, Int}. Status[11:4] hold two saved levels. Status[31:12] always read 0.
- Cause[6:2] ExcCode: 0 = Int, 8 = Sys, 10 = Unimpl, 12 = Ov. All other Cause bits are 0.
- Synchronous exception conditions, in priority order:
  - Unimpl && Status[2]
  - Sys && Status[1]
  - V && OvChk && Status[3]
- Masked exceptions are ignored. The instruction completes normally.
- Interrupt is accepted when all of the following hold: FSM in PEND, Status[0]=1, no synchronous exception, Mtc0=0, Eret=0. If any condition fails, acceptance is deferred. The current instruction is not squashed.
- Entry (any taken exception or interrupt):
  - ExcTaken=1 (interrupt: 0), PcSel=01.
  - At the edge: Status <= {Status[7:0],4'b0} masked to 12 bits; Cause ExcCode <= code.
  - EPC <= Pc for synchronous exceptions; EPC <= Npc for interrupts.
- Eret: PcSel=10, NewPc=Epc. At the edge: Status <= Status>>4 (zero fill).
- Mtc0: writes Wdata to register 12/13/14 at the edge. Status write is masked to [11:0]; Cause write is masked to [6:2]. Other addresses are ignored.
- Mfc0: Rdata = selected register, 0 for unmapped addresses. Rdata is also driven when Mfc0=0.
- Interrupt FSM:
  - IDLE -> PEND when IntR=1.
  - PEND -> ACK on the cycle the interrupt is accepted.
  - ACK: IntA=1 for exactly one cycle, then -> WLOW.
  - WLOW -> IDLE when IntR=0.
  - PEND with IntR dropping before acceptance stays PEND (request is latched).

## Timing
- Reset: Status=STATUS_RST, Cause=0, EPC=0, FSM=IDLE, IntA=0. PcSel and ExcTaken follow their inputs combinationally from the reset register values.
- Reset asserted mid-handling (ACK/WLOW) returns FSM to IDLE. No IntA pulse is emitted.
- ExcTaken, PcSel, NewPc and Rdata are combinational, same cycle as the inputs. Register updates are visible the cycle after.
- IntR first high at edge n -> PEND after edge n. Accept decision is made in cycle n+1 at the earliest. IntA is high during cycle n+2.
- A held-high IntR produces only one IntA until it is seen low.
- Nesting deeper than two levels discards the oldest Status level (shifted out of bit 11).

## Test plan
- Ov trap: Status=0x8, Pc=0x40, OvChk=1, V=1 -> ExcTaken=1, PcSel=01, NewPc=0x8. Next cycle: EPC=0x40, Cause=0x30, Status=0x80.
- Masked/non-trapping overflow: V=1 with OvChk=0, or Status[3]=0 -> ExcTaken=0, PcSel=00, no register change.
- Interrupt handshake: Status=0x1, IntR high at Npc=0x104 -> IntA one-cycle pulse, EPC=0x104, Cause=0, Status=0x10. IntR held high adds no second IntA; it re-arms after IntR=0.
- Interrupt blocked by Mtc0/Eret/sync exception in its accept cycle -> accepted the following eligible cycle. Pending request is retained even if IntR drops.
- Eret: EPC=0x40, Status=0x80 -> PcSel=10, NewPc=0x40. Next cycle Status=0x8.
- Mtc0/Mfc0: write 0xFFFF_FFFF to regs 12, 13, 14 and 3 -> read back 0xFFF, 0x7C, 0xFFFF_FFFF, 0. Sync reset mid-ACK -> all registers at reset values, IntA=0.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// CP0 Status/Cause/EPC with exception/interrupt entry, eret and mtc0/mfc0; outputs combinational, regs update next edge.
// No backpressure: one decision per cycle; a pending interrupt waits for an eligible cycle.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_BASE   = 32'h0000_0008,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Pc,
  input  logic [31:0] Npc,
  input  logic        V,
  input  logic        OvChk,
  input  logic        Sys,
  input  logic        Unimpl,
  input  logic        Mfc0,
  input  logic        Mtc0,
  input  logic        Eret,
  input  logic [4:0]  C0Adr,
  input  logic [31:0] Wdata,
  input  logic        IntR,
  output logic        IntA,
  output logic [31:0] Rdata,
  output logic        ExcTaken,
  output logic [1:0]  PcSel,
  output logic [31:0] NewPc,
  output logic [31:0] Status,
  output logic [31:0] Cause,
  output logic [31:0] Epc
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_WLOW = 2'd3;

  localparam logic [4:0] CODE_INT    = 5'd0;
  localparam logic [4:0] CODE_SYS    = 5'd8;
  localparam logic [4:0] CODE_UNIMPL = 5'd10;
  localparam logic [4:0] CODE_OV     = 5'd12;

  localparam logic [1:0] SEL_NPC  = 2'b00;
  localparam logic [1:0] SEL_EXC  = 2'b01;
  localparam logic [1:0] SEL_EPC  = 2'b10;

  logic [11:0] status_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic [1:0]  state_q;
  logic [1:0]  state_d;

  logic        unimpl_exc;
  logic        sys_exc;
  logic        ov_exc;
  logic        sync_exc;
  logic [4:0]  sync_code;
  logic        int_accept;
  logic        exc_entry;

  assign Status = {20'b0, status_q};
  assign Cause  = {25'b0, exc_code_q, 2'b00};
  assign Epc    = epc_q;
  assign IntA   = (state_q == ST_ACK);

  always_comb begin
    unimpl_exc = Unimpl && status_q[2];
    sys_exc    = Sys && status_q[1];
    ov_exc     = V && OvChk && status_q[3];
    sync_exc   = unimpl_exc || sys_exc || ov_exc;
    sync_code  = CODE_INT;
    if (unimpl_exc)   sync_code = CODE_UNIMPL;
    else if (sys_exc) sync_code = CODE_SYS;
    else if (ov_exc)  sync_code = CODE_OV;
  end

  // An interrupt never squashes: it only takes a cycle that isn't already redirecting or writing CP0.
  assign int_accept = (state_q == ST_PEND) && status_q[0] && !sync_exc && !Mtc0 && !Eret;
  assign exc_entry  = sync_exc || int_accept;
  assign ExcTaken   = sync_exc;

  always_comb begin
    PcSel = SEL_NPC;
    NewPc = 32'h0;
    if (exc_entry) begin
      PcSel = SEL_EXC;
      NewPc = EXC_BASE;
    end else if (Eret) begin
      PcSel = SEL_EPC;
      NewPc = epc_q;
    end
  end

  always_comb begin
    case (C0Adr)
      5'd12:   Rdata = Status;
      5'd13:   Rdata = Cause;
      5'd14:   Rdata = epc_q;
      default: Rdata = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (IntR) state_d = ST_PEND;
      ST_PEND: if (int_accept) state_d = ST_ACK;
      ST_ACK:  state_d = ST_WLOW;
      ST_WLOW: if (!IntR) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      status_q   <= STATUS_RST[11:0];
      exc_code_q <= 5'd0;
      epc_q      <= 32'h0;
      state_q    <= ST_IDLE;
    end else begin
      state_q <= state_d;
      // Entry pushes a fresh level; a third nested level drops the oldest out of bit 11.
      if (exc_entry) begin
        status_q   <= {status_q[7:0], 4'b0000};
        exc_code_q <= sync_exc ? sync_code : CODE_INT;
        epc_q      <= sync_exc ? Pc : Npc;
      end else if (Eret) begin
        status_q <= {4'b0000, status_q[11:4]};
      end else if (Mtc0) begin
        case (C0Adr)
          5'd12:   status_q   <= Wdata[11:0];
          5'd13:   exc_code_q <= Wdata[6:2];
          5'd14:   epc_q      <= Wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomized bench for cp0_exc_ctrl against a behavioural CP0 model, plus directed scenarios.
module tb_cp0_exc_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Pc, Npc, Wdata;
  logic        V, OvChk, Sys, Unimpl, Mfc0, Mtc0, Eret, IntR;
  logic [4:0]  C0Adr;
  logic        IntA, ExcTaken;
  logic [31:0] Rdata, NewPc, Status, Cause, Epc;
  logic [1:0]  PcSel;

  int total = 0;
  int bad   = 0;

  // Model state: register values as plain numbers, interrupt handshake as flags.
  logic [31:0] m_status, m_epc;
  logic [4:0]  m_code;
  bit          m_pend, m_ack, m_wlow;

  always #5 Clk = ~Clk;

  cp0_exc_ctrl #(.EXC_BASE(32'h0000_0008), .STATUS_RST(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .Pc(Pc), .Npc(Npc), .V(V), .OvChk(OvChk),
    .Sys(Sys), .Unimpl(Unimpl), .Mfc0(Mfc0), .Mtc0(Mtc0), .Eret(Eret),
    .C0Adr(C0Adr), .Wdata(Wdata), .IntR(IntR), .IntA(IntA), .Rdata(Rdata),
    .ExcTaken(ExcTaken), .PcSel(PcSel), .NewPc(NewPc), .Status(Status),
    .Cause(Cause), .Epc(Epc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    Reset = 1'b0; V = 1'b0; OvChk = 1'b0; Sys = 1'b0; Unimpl = 1'b0;
    Mfc0 = 1'b0; Mtc0 = 1'b0; Eret = 1'b0; C0Adr = 5'd0; Wdata = 32'h0;
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, advances the model, returns at next posedge+1.
  task automatic cycle();
    logic        sync, acc, entry;
    logic [4:0]  code;
    logic [31:0] exp_rd, exp_newpc;
    logic [1:0]  exp_sel;
    bit          n_pend, n_wlow;
    #3;
    sync = 1'b1;
    if (Unimpl && m_status[2])             code = 5'd10;
    else if (Sys && m_status[1])           code = 5'd8;
    else if (V && OvChk && m_status[3])    code = 5'd12;
    else begin sync = 1'b0; code = 5'd0; end
    acc   = m_pend && m_status[0] && !sync && !Mtc0 && !Eret;
    entry = sync || acc;
    if (entry)     begin exp_sel = 2'b01; exp_newpc = 32'h8; end
    else if (Eret) begin exp_sel = 2'b10; exp_newpc = m_epc; end
    else           begin exp_sel = 2'b00; exp_newpc = 32'h0; end
    if (C0Adr == 5'd12)      exp_rd = m_status;
    else if (C0Adr == 5'd13) exp_rd = 32'(m_code) * 4;
    else if (C0Adr == 5'd14) exp_rd = m_epc;
    else                     exp_rd = 32'h0;

    check("exc_taken", 32'(ExcTaken), 32'(sync));
    check("pc_sel",    32'(PcSel),    32'(exp_sel));
    check("new_pc",    NewPc,         exp_newpc);
    check("rdata",     Rdata,         exp_rd);
    check("int_a",     32'(IntA),     32'(m_ack));
    check("status",    Status,        m_status);
    check("cause",     Cause,         32'(m_code) * 4);
    check("epc",       Epc,           m_epc);

    if (Reset) begin
      m_status = 32'h0; m_code = 5'd0; m_epc = 32'h0;
      m_pend = 1'b0; m_ack = 1'b0; m_wlow = 1'b0;
    end else begin
      if (entry) begin
        m_status = (m_status * 16) % 4096;
        m_code   = sync ? code : 5'd0;
        m_epc    = sync ? Pc : Npc;
      end else if (Eret) begin
        m_status = m_status / 16;
      end else if (Mtc0) begin
        if (C0Adr == 5'd12)      m_status = Wdata % 4096;
        else if (C0Adr == 5'd13) m_code   = 5'((Wdata / 4) % 32);
        else if (C0Adr == 5'd14) m_epc    = Wdata;
      end
      n_pend = m_pend ? !acc : (!m_ack && !m_wlow && IntR);
      n_wlow = m_ack || (m_wlow && IntR);
      m_ack  = acc;
      m_pend = n_pend;
      m_wlow = n_wlow;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic write_c0(input logic [4:0] adr, input logic [31:0] dat);
    idle_inputs(); Mtc0 = 1'b1; C0Adr = adr; Wdata = dat;
    cycle();
  endtask

  initial begin
    m_status = 32'h0; m_code = 5'd0; m_epc = 32'h0;
    m_pend = 1'b0; m_ack = 1'b0; m_wlow = 1'b0;
    idle_inputs(); IntR = 1'b0; Pc = 32'h0; Npc = 32'h4;
    @(posedge Clk); #1;
    Reset = 1'b1; cycle(); cycle();
    idle_inputs();
    check("rst_status", Status, 32'h0);
    check("rst_int_a", 32'(IntA), 32'h0);

    // Overflow trap, then eret back
    write_c0(5'd12, 32'h8);
    idle_inputs(); Pc = 32'h40; Npc = 32'h44; OvChk = 1'b1; V = 1'b1;
    cycle();
    check("ov_epc", Epc, 32'h40);
    check("ov_cause", Cause, 32'h30);
    check("ov_status", Status, 32'h80);
    idle_inputs(); V = 1'b1; cycle();
    idle_inputs(); Eret = 1'b1; cycle();
    check("eret_status", Status, 32'h8);

    // Write masks and readback
    write_c0(5'd12, 32'hFFFF_FFFF);
    write_c0(5'd13, 32'hFFFF_FFFF);
    write_c0(5'd14, 32'hFFFF_FFFF);
    write_c0(5'd3,  32'hFFFF_FFFF);
    idle_inputs(); Mfc0 = 1'b1; C0Adr = 5'd12; #1; check("rd_status", Rdata, 32'hFFF);
    C0Adr = 5'd13; #1; check("rd_cause", Rdata, 32'h7C);
    C0Adr = 5'd14; #1; check("rd_epc", Rdata, 32'hFFFF_FFFF);
    C0Adr = 5'd3;  #1; check("rd_unmapped", Rdata, 32'h0);
    cycle();

    // Interrupt handshake with IntR held high, then re-arm
    write_c0(5'd12, 32'h1);
    idle_inputs(); Pc = 32'h100; Npc = 32'h104; IntR = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("int_epc", Epc, 32'h104);
    check("int_cause", Cause, 32'h0);
    check("int_status", Status, 32'h10);
    IntR = 1'b0; cycle(); cycle();

    // Reset while acknowledging
    write_c0(5'd12, 32'h1);
    idle_inputs(); IntR = 1'b1; cycle(); cycle();
    Reset = 1'b1; cycle();
    idle_inputs(); IntR = 1'b0;
    check("rst_ack_int_a", 32'(IntA), 32'h0);
    check("rst_ack_status", Status, 32'h0);
    check("rst_ack_epc", Epc, 32'h0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int kind;
      idle_inputs();
      Pc  = {$urandom_range(0, 32'h3FFF), 2'b00};
      Npc = Pc + 32'd4;
      kind = $urandom_range(0, 9);
      C0Adr = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(12, 14)) : 5'($urandom_range(0, 31));
      Wdata = $urandom();
      if (kind < 2)       Mtc0 = 1'b1;
      else if (kind == 2) Eret = 1'b1;
      else begin
        Mfc0   = (kind == 3);
        Unimpl = ($urandom_range(0, 7) == 0);
        Sys    = ($urandom_range(0, 7) == 0);
        OvChk  = ($urandom_range(0, 3) == 0);
        V      = $urandom_range(0, 1) != 0;
      end
      if ($urandom_range(0, 7) == 0) IntR = ~IntR;
      Reset = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
